// File: rtl/chip8_pkg.sv
// Shared CHIP-8 display constants and the sprite-draw state encoding.
// The scan-out path uses the same geometry and {y, x} framebuffer layout.
package chip8_pkg;

   localparam int X_MAX         = 64;
   localparam int Y_MAX         = 32;
   localparam int X_ADDR_WIDTH  = $clog2(X_MAX);
   localparam int Y_ADDR_WIDTH  = $clog2(Y_MAX);
   localparam int FB_ADDR_WIDTH = 11;
   localparam int ROW_CYCLES    = 18;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      PIX_RD,
      PIX_WR,
      CLEAR,
      DONE
   } draw_state_e;

endpackage

// File: rtl/sprite_draw.sv
// DXYN / 00E0 executor: XORs sprite rows into the 1-bit framebuffer and
// reports the VF collision flag. Owns the framebuffer write port.
module sprite_draw
   import chip8_pkg::*;
#(
   parameter int X_MAX          = chip8_pkg::X_MAX,
   parameter int Y_MAX          = chip8_pkg::Y_MAX,
   parameter int MEM_ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_draw,
   input  logic                      start_clear,
   input  logic [7:0]                vx,
   input  logic [7:0]                vy,
   input  logic [3:0]                n,
   input  logic [MEM_ADDR_WIDTH-1:0] i_addr,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_rd,
   input  logic [7:0]                mem_data,
   output logic [10:0]               fb_addr,
   output logic                      fb_rd,
   input  logic                      fb_rd_data,
   output logic                      fb_we,
   output logic                      fb_wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      collision
);

   localparam int XW = $clog2(X_MAX);
   localparam int YW = $clog2(Y_MAX);

   draw_state_e                state_q, state_d;
   logic [XW-1:0]              x0_q, x0_d;
   logic [YW-1:0]              y0_q, y0_d;
   logic [3:0]                 n_q, n_d;
   logic [MEM_ADDR_WIDTH-1:0]  base_q, base_d;
   logic [3:0]                 row_q, row_d;
   logic [2:0]                 bit_q, bit_d;
   logic [7:0]                 shift_q, shift_d;
   logic [FB_ADDR_WIDTH-1:0]   clr_q, clr_d;
   logic                       coll_q, coll_d;

   // Power-of-two geometry: wrap at both edges falls out of the truncating adds.
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   assign px = x0_q + XW'(bit_q);
   assign py = y0_q + YW'(row_q);

   assign collision = coll_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         n_q     <= '0;
         base_q  <= '0;
         row_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         clr_q   <= '0;
         coll_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         n_q     <= n_d;
         base_q  <= base_d;
         row_q   <= row_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         clr_q   <= clr_d;
         coll_q  <= coll_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      x0_d       = x0_q;
      y0_d       = y0_q;
      n_d        = n_q;
      base_d     = base_q;
      row_d      = row_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      clr_d      = clr_q;
      coll_d     = coll_q;
      mem_rd     = 1'b0;
      mem_addr   = '0;
      fb_rd      = 1'b0;
      fb_we      = 1'b0;
      fb_wr_data = 1'b0;
      fb_addr    = '0;
      done       = 1'b0;
      busy       = (state_q != IDLE) && (state_q != DONE);

      case (state_q)
         IDLE: begin
            if (start_clear) begin
               clr_d   = '0;
               coll_d  = 1'b0;
               state_d = CLEAR;
            end else if (start_draw) begin
               x0_d    = vx[XW-1:0];
               y0_d    = vy[YW-1:0];
               n_d     = n;
               base_d  = i_addr;
               row_d   = '0;
               coll_d  = 1'b0;
               state_d = (n == 4'd0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            mem_rd   = 1'b1;
            mem_addr = base_q + MEM_ADDR_WIDTH'(row_q);
            state_d  = LATCH;
         end
         LATCH: begin
            shift_d = mem_data;
            bit_d   = '0;
            state_d = PIX_RD;
         end
         PIX_RD: begin
            fb_rd   = 1'b1;
            fb_addr = FB_ADDR_WIDTH'({py, px});
            state_d = PIX_WR;
         end
         PIX_WR: begin
            // Old pixel arrives from the RAM's registered read this cycle.
            fb_addr    = FB_ADDR_WIDTH'({py, px});
            fb_we      = shift_q[7];
            fb_wr_data = ~fb_rd_data;
            coll_d     = coll_q | (shift_q[7] & fb_rd_data);
            shift_d    = {shift_q[6:0], 1'b0};
            if (bit_q == 3'd7) begin
               if (row_q == n_q - 4'd1) begin
                  state_d = DONE;
               end else begin
                  row_d   = row_q + 4'd1;
                  state_d = FETCH;
               end
            end else begin
               bit_d   = bit_q + 3'd1;
               state_d = PIX_RD;
            end
         end
         CLEAR: begin
            fb_we   = 1'b1;
            fb_addr = clr_q;
            clr_d   = clr_q + 1'b1;
            if (clr_q == '1) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sprite_draw.sv
// Directed bench for sprite_draw: a per-cycle expected trace is derived from
// the cycle formulas and a reference framebuffer, and checked every cycle.
module tb_sprite_draw;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_draw = 1'b0;
   logic        start_clear = 1'b0;
   logic [7:0]  vx = '0;
   logic [7:0]  vy = '0;
   logic [3:0]  n = '0;
   logic [11:0] i_addr = '0;
   logic [11:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic [10:0] fb_addr;
   logic        fb_rd;
   logic        fb_rd_data;
   logic        fb_we;
   logic        fb_wr_data;
   logic        busy;
   logic        done;
   logic        collision;

   sprite_draw #(.X_MAX(64), .Y_MAX(32), .MEM_ADDR_WIDTH(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_draw(start_draw), .start_clear(start_clear),
      .vx(vx), .vy(vy), .n(n), .i_addr(i_addr),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
      .fb_addr(fb_addr), .fb_rd(fb_rd), .fb_rd_data(fb_rd_data),
      .fb_we(fb_we), .fb_wr_data(fb_wr_data),
      .busy(busy), .done(done), .collision(collision)
   );

   always #5 clk = ~clk;

   // Environment: main memory and framebuffer RAM, both with 1-cycle reads.
   logic [7:0] mem [0:4095];
   logic       fb_env [0:2047];
   logic       init_fb = 1'b1;

   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   always @(posedge clk) begin
      if (init_fb) begin
         for (int k = 0; k < 2048; k++) fb_env[k] <= 1'b0;
      end else if (fb_we) begin
         fb_env[fb_addr] <= fb_wr_data;
      end
      if (fb_rd) fb_rd_data <= fb_env[fb_addr];
   end

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        mem_rd;
      logic [11:0] mem_addr;
      logic        fb_rd;
      logic        fb_we;
      logic        fb_wr_data;
      logic [10:0] fb_addr;
      logic        chk_addr;
      logic        coll;
   } exp_t;

   typedef struct {
      string nm;
      int    act;
      int    req;
   } pin_t;

   exp_t exp_q[$];
   pin_t pin_q[$];
   bit   ref_fb [0:2047];
   int   vectors = 0;
   int   miscompares = 0;
   bit   last_coll = 1'b0;
   bit   bad;

   // Expected trace of a DXYN: cycle 18r+1 fetch, 18r+3+2b read, 18r+4+2b write.
   task automatic gen_draw(input int gx, input int gy, input int gn, input int ia);
      exp_t       e;
      logic [7:0] row_byte;
      int         a;
      bit         sb;
      bit         coll = 1'b0;
      for (int r = 0; r < gn; r++) begin
         row_byte = mem[(ia + r) % 4096];
         e = '0; e.busy = 1'b1; e.mem_rd = 1'b1; e.mem_addr = 12'((ia + r) % 4096);
         exp_q.push_back(e);
         e = '0; e.busy = 1'b1;
         exp_q.push_back(e);
         for (int b = 0; b < 8; b++) begin
            a  = (((gy % 32) + r) % 32) * 64 + (((gx % 64) + b) % 64);
            sb = row_byte[7-b];
            e = '0; e.busy = 1'b1; e.fb_rd = 1'b1; e.fb_addr = 11'(a); e.chk_addr = 1'b1;
            exp_q.push_back(e);
            e = '0; e.busy = 1'b1; e.fb_we = sb; e.fb_wr_data = ~ref_fb[a];
            e.fb_addr = 11'(a); e.chk_addr = 1'b1;
            exp_q.push_back(e);
            if (sb) begin
               coll = coll | ref_fb[a];
               ref_fb[a] = ~ref_fb[a];
            end
         end
      end
      e = '0; e.done = 1'b1; e.coll = coll;
      exp_q.push_back(e);
   endtask

   task automatic gen_clear();
      exp_t e;
      for (int k = 0; k < 2048; k++) begin
         e = '0; e.busy = 1'b1; e.fb_we = 1'b1; e.fb_addr = 11'(k); e.chk_addr = 1'b1;
         exp_q.push_back(e);
         ref_fb[k] = 1'b0;
      end
      e = '0; e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic pin(input string nm, input int act, input int req);
      pin_t p;
      p.nm = nm; p.act = act; p.req = req;
      pin_q.push_back(p);
   endtask

   task automatic cmp(input string nm, input int act, input int req);
      if (act != req) begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
         bad = 1'b1;
      end
   endtask

   // Single compare process: owns both counters.
   initial forever begin
      pin_t p;
      exp_t e;
      @(posedge clk);
      #1;
      while (pin_q.size() > 0) begin
         p = pin_q.pop_front();
         vectors++;
         if (p.act != p.req) begin
            $display("FAIL %s: got %0h, expected %0h", p.nm, p.act, p.req);
            miscompares++;
         end
      end
      bad = 1'b0;
      if (!rst_n) begin
         cmp("rst_mem_addr", mem_addr, 0); cmp("rst_mem_rd", mem_rd, 0);
         cmp("rst_fb_addr", fb_addr, 0);   cmp("rst_fb_rd", fb_rd, 0);
         cmp("rst_fb_we", fb_we, 0);       cmp("rst_fb_wr_data", fb_wr_data, 0);
         cmp("rst_busy", busy, 0);         cmp("rst_done", done, 0);
         cmp("rst_collision", collision, 0);
         last_coll = 1'b0;
      end else if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cmp("busy", busy, e.busy);
         cmp("done", done, e.done);
         cmp("mem_rd", mem_rd, e.mem_rd);
         if (e.mem_rd) cmp("mem_addr", mem_addr, e.mem_addr);
         cmp("fb_rd", fb_rd, e.fb_rd);
         cmp("fb_we", fb_we, e.fb_we);
         if (e.chk_addr) cmp("fb_addr", fb_addr, e.fb_addr);
         if (e.fb_we) cmp("fb_wr_data", fb_wr_data, e.fb_wr_data);
         if (e.done) begin
            cmp("collision", collision, e.coll);
            last_coll = e.coll;
         end
      end else begin
         cmp("idle_busy", busy, 0);   cmp("idle_done", done, 0);
         cmp("idle_mem_rd", mem_rd, 0); cmp("idle_fb_rd", fb_rd, 0);
         cmp("idle_fb_we", fb_we, 0); cmp("idle_collision", collision, last_coll);
      end
      vectors++;
      if (bad) miscompares++;
   end

   // Presents a start at a negedge; the trace is queued in the same timestep.
   task automatic begin_op(input bit clr, input bit drw, input int ox, input int oy,
                           input int on, input int oi);
      @(negedge clk);
      if (clr) gen_clear();
      else if (drw) gen_draw(ox, oy, on, oi);
      start_clear = clr; start_draw = drw;
      vx = 8'(ox); vy = 8'(oy); n = 4'(on); i_addr = 12'(oi);
      $display("op clr=%0d draw=%0d vx=%0d vy=%0d n=%0d i=%03h", clr, drw, ox, oy, on, oi);
   endtask

   task automatic end_start(input int hold);
      repeat (hold) @(negedge clk);
      start_clear = 1'b0; start_draw = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      int diffs = 0;
      while (exp_q.size() > 0 && t < 5000) begin
         @(negedge clk);
         t++;
      end
      pin({nm, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2048; k++) diffs += (fb_env[k] != ref_fb[k]) ? 1 : 0;
      pin({nm, "_fb_contents"}, diffs, 0);
   endtask

   initial begin
      for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
      mem[12'h200] = 8'hF0;
      mem[12'hFFF] = 8'hFF;
      mem[12'h000] = 8'hFF;
      repeat (3) @(negedge clk);
      init_fb = 1'b0;
      rst_n   = 1'b1;

      // Reset in the middle of a clear, then the next draw must be accepted.
      begin_op(1, 0, 0, 0, 0, 0);
      end_start(1);
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      $display("op reset released mid-clear");
      repeat (2) @(negedge clk);

      begin_op(0, 1, 0, 0, 1, 12'h200);
      pin("draw1_len", exp_q.size(), 19);
      pin("draw1_ref_on", ref_fb[0] + ref_fb[1] + ref_fb[2] + ref_fb[3], 4);
      pin("draw1_ref_off", ref_fb[4], 0);
      pin("draw1_we_x0", exp_q[3].fb_we, 1);
      pin("draw1_we_x4", exp_q[11].fb_we, 0);
      pin("draw1_coll", exp_q[18].coll, 0);
      end_start(1);
      wait_idle("draw1");

      begin_op(0, 1, 0, 0, 1, 12'h200);
      pin("draw2_wdata", exp_q[3].fb_wr_data, 0);
      pin("draw2_coll", exp_q[18].coll, 1);
      end_start(1);
      wait_idle("draw2");

      begin_op(0, 1, 62, 31, 2, 12'hFFF);
      pin("wrap_len", exp_q.size(), 37);
      pin("wrap_maddr0", exp_q[0].mem_addr, 12'hFFF);
      pin("wrap_maddr1", exp_q[18].mem_addr, 12'h000);
      pin("wrap_addr_r0b0", exp_q[2].fb_addr, 31 * 64 + 62);
      pin("wrap_addr_r0b2", exp_q[6].fb_addr, 31 * 64 + 0);
      pin("wrap_addr_r1b0", exp_q[20].fb_addr, 62);
      end_start(1);
      wait_idle("wrap");

      // Clear wins over a simultaneous draw; a draw pulsed at cycle 100 is ignored.
      begin_op(1, 1, 5, 5, 3, 12'h200);
      pin("clear_len", exp_q.size(), 2049);
      pin("clear_last_addr", exp_q[2047].fb_addr, 2047);
      end_start(1);
      repeat (99) @(negedge clk);
      start_draw = 1'b1; vx = 8'd10; vy = 8'd10; n = 4'd2;
      @(negedge clk);
      start_draw = 1'b0;
      wait_idle("clear");

      // n=0: immediate done; a start held into the DONE cycle is ignored.
      begin_op(0, 1, 200, 0, 0, 12'h300);
      pin("n0_len", exp_q.size(), 1);
      pin("n0_done", exp_q[0].done, 1);
      end_start(2);
      wait_idle("n0");

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
